ecc_encoder: RTL

- Transmit-side counterpart of the single-error-correcting decoder: converts a raw data word into an extended-Hamming codeword (SEC-DED) of 8, 16 or 32 bits.
- Bit layout matches what the decoder's syndrome-to-bit mapping expects.
- Multi-cycle: one check bit per cycle, then overall parity, then a registered codeword with a one-cycle done strobe.
- Sits between the register/APB front end and the channel, alongside the decoder.

---
 rtl/ecc_encoder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ecc_encoder.sv
// ecc_encoder: turns a raw data word into an extended-Hamming (SEC-DED) codeword of 8, 16 or 32 bits.
// Latency: Start sampled on edge 0, one check bit per edge, then parity; Enc_Done high after edge K+1 (4/5/6).
// Backpressure: none; Start is only accepted in IDLE, and requests while Busy are dropped, not queued.
//
// Ports:
//   clk      - system clock, rising-edge
//   rst      - asynchronous active-low reset
//   Start    - encode request, sampled in IDLE only
//   Small    - 8-bit codeword mode (4 data bits, 3 check bits), wins over Medium
//   Medium   - 16-bit codeword mode (11 data bits, 4 check bits)
//   DATA_IN  - right-justified data word; bits above the mode's data width are ignored
//   Enc_Out  - registered codeword: C[K-1:0] at bits K-1..0, overall parity at bit K, data above
//   Enc_Done - one-cycle strobe, Enc_Out valid
//   Busy     - high whenever the FSM is not in IDLE
module ecc_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int AMBA_WORD  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic                  Small,
    input  logic                  Medium,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic [AMBA_WORD-1:0]  Enc_Out,
    output logic                  Enc_Done,
    output logic                  Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        PAR  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Mode encoding: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit codeword
    localparam logic [1:0] MODE_S = 2'd0;
    localparam logic [1:0] MODE_M = 2'd1;
    localparam logic [1:0] MODE_L = 2'd2;

    state_t               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [25:0]          data_q, data_d;
    logic [4:0]           chk_q, chk_d;
    logic [2:0]           idx_q, idx_d;
    logic [AMBA_WORD-1:0] out_q, out_d;

    // Zero-extend / truncate DATA_IN to the 26-bit maximum payload
    logic [DATA_WIDTH+25:0] din_pad;
    logic [25:0]            din_ext;
    logic                   unused_din;
    assign din_pad    = {26'd0, DATA_IN};
    assign din_ext    = din_pad[25:0];
    assign unused_din = ^din_pad[DATA_WIDTH+25:26];

    // Mode and payload mask decided at Start time
    logic [1:0]  start_mode;
    logic [25:0] start_mask;
    always_comb begin
        start_mode = MODE_L;
        start_mask = 26'h3FF_FFFF;
        if (Small) begin
            start_mode = MODE_S;
            start_mask = 26'h000_000F;
        end else if (Medium) begin
            start_mode = MODE_M;
            start_mask = 26'h000_07FF;
        end
    end

    // Index of the last check bit for the latched mode (K-1)
    logic [2:0] k_last;
    always_comb begin
        case (mode_q)
            MODE_S:  k_last = 3'd2;
            MODE_M:  k_last = 3'd3;
            default: k_last = 3'd4;
        endcase
    end

    // Data bits covered by check bit idx: walk the non-power-of-two positions
    // 3,5,6,7,9,... in order; data bit n sits at the n-th such position.
    logic [25:0] cover_mask;
    logic [4:0]  cnt;
    logic [4:0]  pb;
    always_comb begin
        cover_mask = '0;
        cnt        = '0;
        pb         = '0;
        for (int p = 3; p < 32; p++) begin
            pb = p[4:0];
            if ((pb & (pb - 5'd1)) != 5'd0) begin
                cover_mask[cnt] = pb[idx_q];
                cnt             = cnt + 5'd1;
            end
        end
    end

    logic chk_bit;
    assign chk_bit = ^(data_q & cover_mask);

    // Payload was masked at Start and unused check bits stay zero, so a plain
    // reduction over both registers gives the even overall parity.
    logic par_bit;
    assign par_bit = (^data_q) ^ (^chk_q);

    logic [31:0] cw;
    always_comb begin
        case (mode_q)
            MODE_S:  cw = {24'd0, data_q[3:0], par_bit, chk_q[2:0]};
            MODE_M:  cw = {16'd0, data_q[10:0], par_bit, chk_q[3:0]};
            default: cw = {data_q[25:0], par_bit, chk_q[4:0]};
        endcase
    end

    logic [AMBA_WORD+31:0] cw_pad;
    logic                  unused_cw;
    assign cw_pad    = {{AMBA_WORD{1'b0}}, cw};
    assign unused_cw = ^cw_pad[AMBA_WORD+31:AMBA_WORD];

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        data_d  = data_q;
        chk_d   = chk_q;
        idx_d   = idx_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    data_d  = din_ext & start_mask;
                    mode_d  = start_mode;
                    chk_d   = '0;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                chk_d[idx_q] = chk_bit;
                idx_d        = idx_q + 3'd1;
                if (idx_q == k_last) begin
                    state_d = PAR;
                end
            end
            PAR: begin
                out_d   = cw_pad[AMBA_WORD-1:0];
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_S;
            data_q  <= '0;
            chk_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            chk_q   <= chk_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
        end
    end

    assign Enc_Out  = out_q;
    assign Enc_Done = (state_q == DONE);
    assign Busy     = (state_q != IDLE);

endmodule
